// File: rtl/roman2bin_if.sv
// Symbol-beat input / decoded-value output bundle for the roman2bin decoder.
interface roman2bin_if #(
  parameter int VAL_WIDTH = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_sym;
  logic                 in_last;
  logic                 out_valid;
  logic [VAL_WIDTH-1:0] out_value;
  logic                 out_err;

  modport master (
    output in_valid, in_sym, in_last,
    input  in_ready, out_valid, out_value, out_err
  );

  modport slave (
    input  in_valid, in_sym, in_last,
    output in_ready, out_valid, out_value, out_err
  );
endinterface

// File: rtl/roman2bin.sv
// Roman-numeral stream decoder: folds 3-bit symbol beats into one binary value per group.
// Define ROMAN2BIN_STRICT_EN to also reject non-canonical numerals (bad pairs, over-repeats).
module roman2bin #(
  parameter int VAL_WIDTH = 12,
  parameter int MAX_SYM   = 15
) (
  input  logic       clk,
  input  logic       rst,
  roman2bin_if.slave bus
);

  localparam int ACC_W   = VAL_WIDTH + 2;
  localparam int CNT_W   = $clog2(MAX_SYM + 2);
  localparam int MAX_VAL = (1 << VAL_WIDTH) - 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]              prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [VAL_WIDTH-1:0]    value_q, value_d;
  logic                    oerr_q, oerr_d;
  int                      sum_c, fin_c;
  logic                    grp_err_c;
`ifdef ROMAN2BIN_STRICT_EN
  logic [1:0]              run_q, run_d;
  logic [2:0]              seen_q, seen_d;
`endif

  function automatic int sym_val(input logic [2:0] s);
    case (s)
      3'd1:    return 1;
      3'd2:    return 5;
      3'd3:    return 10;
      3'd4:    return 50;
      3'd5:    return 100;
      3'd6:    return 500;
      3'd7:    return 1000;
      default: return 0;
    endcase
  endfunction

`ifdef ROMAN2BIN_STRICT_EN
  function automatic logic pair_ok(input logic [2:0] p, input logic [2:0] c);
    return (p == 3'd1 && (c == 3'd2 || c == 3'd3)) ||
           (p == 3'd3 && (c == 3'd4 || c == 3'd5)) ||
           (p == 3'd5 && (c == 3'd6 || c == 3'd7));
  endfunction
`endif

  // The previous symbol stays pending until the next one shows whether it adds or subtracts.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    value_d   = value_q;
    oerr_d    = oerr_q;
    sum_c     = 0;
    fin_c     = 0;
    grp_err_c = 1'b0;
`ifdef ROMAN2BIN_STRICT_EN
    run_d     = run_q;
    seen_d    = seen_q;
`endif
    case (state_q)
      IDLE, ACC: begin
        if (bus.in_valid) begin
          if (bus.in_sym != 3'd0) begin
            if (prev_q != 3'd0 && sym_val(prev_q) < sym_val(bus.in_sym))
              sum_c = int'(acc_q) - sym_val(prev_q);
            else
              sum_c = int'(acc_q) + sym_val(prev_q);
            // A running sum past the limit can never come back down, so flag it now.
            if (sum_c > MAX_VAL)
              err_d = 1'b1;
            acc_d  = sum_c[ACC_W-1:0];
            prev_d = bus.in_sym;
            if (cnt_q != CNT_W'(MAX_SYM + 1))
              cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d > CNT_W'(MAX_SYM))
              err_d = 1'b1;
            state_d = ACC;
`ifdef ROMAN2BIN_STRICT_EN
            if (prev_q != 3'd0 && sym_val(prev_q) < sym_val(bus.in_sym) &&
                !pair_ok(prev_q, bus.in_sym))
              err_d = 1'b1;
            if (bus.in_sym == prev_q) begin
              if (run_q == 2'd3 && bus.in_sym[0])
                err_d = 1'b1;
              if (run_q != 2'd3)
                run_d = run_q + 2'd1;
            end else begin
              run_d = 2'd1;
            end
            case (bus.in_sym)
              3'd2: begin err_d = err_d | seen_q[0]; seen_d[0] = 1'b1; end
              3'd4: begin err_d = err_d | seen_q[1]; seen_d[1] = 1'b1; end
              3'd6: begin err_d = err_d | seen_q[2]; seen_d[2] = 1'b1; end
              default: ;
            endcase
`endif
          end
          if (bus.in_last) begin
            fin_c     = int'(acc_d) + sym_val(prev_d);
            grp_err_c = err_d || (cnt_d == '0) || (fin_c < 0) || (fin_c > MAX_VAL);
            oerr_d    = grp_err_c;
            value_d   = grp_err_c ? '0 : fin_c[VAL_WIDTH-1:0];
            state_d   = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        prev_d  = 3'd0;
        cnt_d   = '0;
        err_d   = 1'b0;
`ifdef ROMAN2BIN_STRICT_EN
        run_d   = 2'd0;
        seen_d  = 3'd0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      prev_q  <= 3'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      value_q <= '0;
      oerr_q  <= 1'b0;
`ifdef ROMAN2BIN_STRICT_EN
      run_q   <= 2'd0;
      seen_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      value_q <= value_d;
      oerr_q  <= oerr_d;
`ifdef ROMAN2BIN_STRICT_EN
      run_q   <= run_d;
      seen_q  <= seen_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_value = value_q;
  assign bus.out_err   = oerr_q;

endmodule

// File: tb/tb_roman2bin.sv
// Self-checking bench for roman2bin: directed numerals plus random symbol groups
// compared against a plain-arithmetic Roman numeral model.
module tb_roman2bin;
  localparam int VAL_WIDTH = 12;
  localparam int MAX_SYM   = 15;
  localparam int MAX_VAL   = 4095;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   grp[$];
  int   vals[8] = '{0, 1, 5, 10, 50, 100, 500, 1000};

  roman2bin_if #(.VAL_WIDTH(VAL_WIDTH)) bus ();

  roman2bin #(.VAL_WIDTH(VAL_WIDTH), .MAX_SYM(MAX_SYM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int char_code(input byte c);
    case (c)
      "I": return 1;
      "V": return 2;
      "X": return 3;
      "L": return 4;
      "C": return 5;
      "D": return 6;
      "M": return 7;
      default: return 0;
    endcase
  endfunction

  task automatic load(input string s);
    grp.delete();
    for (int i = 0; i < s.len(); i++) grp.push_back(char_code(s[i]));
  endtask

  // Each value is subtracted when the next non-blank value is larger, otherwise added.
  function automatic void ref_model(output int value, output bit err);
    int v[$];
    int total;
    err   = 1'b0;
    total = 0;
    foreach (grp[i]) if (grp[i] != 0) v.push_back(vals[grp[i]]);
    if (v.size() == 0) err = 1'b1;
    if (v.size() > MAX_SYM) err = 1'b1;
    foreach (v[i]) begin
      if (i + 1 < v.size() && v[i] < v[i+1]) total -= v[i];
      else total += v[i];
    end
    if (total < 0 || total > MAX_VAL) err = 1'b1;
`ifdef ROMAN2BIN_STRICT_EN
    begin
      int run;
      int n5, n50, n500;
      run = 0; n5 = 0; n50 = 0; n500 = 0;
      foreach (v[i]) begin
        if (i + 1 < v.size() && v[i] < v[i+1] && v[i+1] != 5*v[i] && v[i+1] != 10*v[i]) err = 1'b1;
        run = (i > 0 && v[i] == v[i-1]) ? run + 1 : 1;
        if (run >= 4 && (v[i] == 1 || v[i] == 10 || v[i] == 100 || v[i] == 1000)) err = 1'b1;
        if (v[i] == 5) n5++;
        if (v[i] == 50) n50++;
        if (v[i] == 500) n500++;
      end
      if (n5 > 1 || n50 > 1 || n500 > 1) err = 1'b1;
    end
`endif
    value = err ? 0 : total;
  endfunction

  // Leaves the bench at the falling edge of the cycle after the last beat was accepted.
  task automatic send_group(input int gap_pct);
    for (int i = 0; i < grp.size(); i++) begin
      int t;
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_sym   = 3'($urandom);
        bus.in_last  = 1'($urandom);
        @(negedge clk);
      end
      t = 0;
      while (!bus.in_ready && t < 8) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL ready_timeout in_ready=%0b required=1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_sym   = 3'(grp[i]);
      bus.in_last  = (i == grp.size() - 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sym   = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sym   = 3'd0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", bus.out_valid); end
    if (bus.out_value !== '0) begin errors++; $display("[TB] FAIL reset_value got %0d exp 0", bus.out_value); end
    if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b exp 0", bus.out_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    string pats[10] = '{"XLII", "0000IX", "IIIIIIIIIIIIIIII", "MMMMM", "MMMCMXCIX",
                        "IIII", "IC", "VV", "IIIIIIIIIIIIIII", "MMMMXCV"};
    int exp_v[10];
    bit exp_e[10];
`ifdef ROMAN2BIN_STRICT_EN
    exp_v = '{42, 9, 0, 0, 3999, 0, 0, 0, 0, 0};
    exp_e = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
`else
    exp_v = '{42, 9, 0, 0, 3999, 4, 99, 10, 15, 4095};
    exp_e = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 10; i++) begin
      load(pats[i]);
      send_group(0);
      checks += 4;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir_valid %s got %0b exp 1", pats[i], bus.out_valid); end
      if (bus.out_value !== VAL_WIDTH'(exp_v[i])) begin errors++; $display("[TB] FAIL dir_value %s got %0d exp %0d", pats[i], bus.out_value, exp_v[i]); end
      if (bus.out_err !== exp_e[i]) begin errors++; $display("[TB] FAIL dir_err %s got %0b exp %0b", pats[i], bus.out_err, exp_e[i]); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dir_ready_done %s got %0b exp 0", pats[i], bus.in_ready); end
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dir_pulse %s got %0b exp 0", pats[i], bus.out_valid); end
      if (bus.out_value !== VAL_WIDTH'(exp_v[i])) begin errors++; $display("[TB] FAIL dir_hold %s got %0d exp %0d", pats[i], bus.out_value, exp_v[i]); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dir_ready_idle %s got %0b exp 1", pats[i], bus.in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    load("MCMXCIV");
    send_group(0);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid1 got %0b exp 1", bus.out_valid); end
    if (bus.out_value !== VAL_WIDTH'(1994)) begin errors++; $display("[TB] FAIL b2b_value1 got %0d exp 1994", bus.out_value); end
    if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err1 got %0b exp 0", bus.out_err); end
    load("0");
    send_group(0);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid2 got %0b exp 1", bus.out_valid); end
    if (bus.out_value !== '0) begin errors++; $display("[TB] FAIL b2b_value2 got %0d exp 0", bus.out_value); end
    if (bus.out_err !== 1'b1) begin errors++; $display("[TB] FAIL b2b_err2 got %0b exp 1", bus.out_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_group();
    load("XX");
    grp.push_back(0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_sym  = 3'd3;
      bus.in_last = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %0b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %0b exp 0", bus.out_valid); end
    load("V");
    send_group(0);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_res_valid got %0b exp 1", bus.out_valid); end
    if (bus.out_value !== VAL_WIDTH'(5)) begin errors++; $display("[TB] FAIL midrst_value got %0d exp 5", bus.out_value); end
    if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err got %0b exp 0", bus.out_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_done();
    load("XLII");
    send_group(0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL donerst_pre got %0b exp 1", bus.out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL donerst_valid got %0b exp 0", bus.out_valid); end
    if (bus.out_value !== '0) begin errors++; $display("[TB] FAIL donerst_value got %0d exp 0", bus.out_value); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL donerst_ready got %0b exp 1", bus.in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int exp_val;
    bit exp_err;
    for (int n = 0; n < 60; n++) begin
      int len;
      len = int'($urandom_range(1, 18));
      grp.delete();
      for (int k = 0; k < len; k++) grp.push_back(int'($urandom_range(0, 7)));
      ref_model(exp_val, exp_err);
      send_group(25);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rnd_valid #%0d got %0b exp 1", n, bus.out_valid); end
      if (bus.out_value !== VAL_WIDTH'(exp_val)) begin errors++; $display("[TB] FAIL rnd_value #%0d got %0d exp %0d", n, bus.out_value, exp_val); end
      if (bus.out_err !== exp_err) begin errors++; $display("[TB] FAIL rnd_err #%0d got %0b exp %0b", n, bus.out_err, exp_err); end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] roman2bin bench start");
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_group();
    test_reset_in_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
